// File: rtl/aes_stream_core_if.sv
// Streaming handshake bundle for aes_stream_core: key load, block input and result output.
// The ctr_init field exists only when AES_STREAM_CTR_EN is defined.
interface aes_stream_core_if #(
  parameter int KEY_BITS = 128
);
  logic                key_valid;
  logic                key_ready;
  logic [KEY_BITS-1:0] key;
  logic                key_loaded;
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        in_data;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        out_data;
  logic                busy;
`ifdef AES_STREAM_CTR_EN
  logic [127:0]        ctr_init;

  modport master (
    output key_valid, key, in_valid, in_data, out_ready, ctr_init,
    input  key_ready, key_loaded, in_ready, out_valid, out_data, busy
  );
  modport slave (
    input  key_valid, key, in_valid, in_data, out_ready, ctr_init,
    output key_ready, key_loaded, in_ready, out_valid, out_data, busy
  );
`else
  modport master (
    output key_valid, key, in_valid, in_data, out_ready,
    input  key_ready, key_loaded, in_ready, out_valid, out_data, busy
  );
  modport slave (
    input  key_valid, key, in_valid, in_data, out_ready,
    output key_ready, key_loaded, in_ready, out_valid, out_data, busy
  );
`endif
endinterface

// File: rtl/aes_stream_core.sv
// Iterative AES-128/256 encryptor: cached round keys, one round per clock, valid/ready streaming.
// Define AES_STREAM_CTR_EN for counter mode (ctr_init captured on key load), otherwise ECB.
module aes_stream_core #(
  parameter int KEY_BITS = 128
) (
  input logic              clk,
  input logic              rst,
  aes_stream_core_if.slave bus
);
  localparam int NR  = (KEY_BITS == 256) ? 14 : 10;
  localparam int NK  = KEY_BITS / 32;
  localparam logic [3:0] NR4  = 4'(NR);
  localparam logic [3:0] NKB4 = 4'(NK / 4);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_stream_core: KEY_BITS must be 128 or 256");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, KEY_EXP, READY, ROUND, OUT} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    gf_mul = p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    sbox = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 2; i < 16; i++) r = (4'(i) <= n) ? xtime(r) : r;
    rcon = r;
  endfunction

  // Round-key block j from block j-1 (for w[i-1]) and block j-Nk/4 (for w[i-Nk])
  function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [127:0] base,
                                            input logic [3:0] j);
    logic [31:0] t;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    logic [3:0]  ridx;
    ridx = (NK == 8) ? {1'b0, j[3:1]} : j;
    if (NK == 8 && j[0]) t = sub_word(prev[31:0]);
    else t = sub_word({prev[23:0], prev[31:24]}) ^ {rcon(ridx), 24'h000000};
    w0 = base[127:96] ^ t;
    w1 = base[95:64] ^ w0;
    w2 = base[63:32] ^ w1;
    w3 = base[31:0] ^ w2;
    key_step = {w0, w1, w2, w3};
  endfunction

  // SubBytes, ShiftRows, MixColumns (skipped when last) and AddRoundKey; byte n = row n%4, col n/4
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   m [4];
    logic [127:0] r;
    for (int n = 0; n < 16; n++) b[n] = sbox(s[127-8*n -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        t[rr + 4*c] = b[rr + 4*((c + rr) % 4)];
    for (int c = 0; c < 4; c++) begin
      m[0] = xtime(t[4*c]) ^ xtime(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
      m[1] = t[4*c] ^ xtime(t[4*c+1]) ^ xtime(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
      m[2] = t[4*c] ^ t[4*c+1] ^ xtime(t[4*c+2]) ^ xtime(t[4*c+3]) ^ t[4*c+3];
      m[3] = xtime(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xtime(t[4*c+3]);
      for (int k = 0; k < 4; k++) r[127-8*(4*c+k) -: 8] = last ? t[4*c+k] : m[k];
    end
    enc_round = r ^ rk;
  endfunction

  state_t       state_r;
  logic [127:0] rk_r [NR+1];
  logic [3:0]   cnt_r;
  logic [127:0] st_r;
  logic [127:0] out_data_r;
  logic         key_loaded_r;
  logic         key_ready_r;
  logic         in_open_r;
  logic         out_valid_r;
  logic         busy_r;
  logic [127:0] kexp_next_s;
  logic [127:0] round_next_s;
  logic [127:0] blk_src_s;
  logic [127:0] out_next_s;
  logic         key_fire_s;
  logic         in_fire_s;
  logic         out_fire_s;
`ifdef AES_STREAM_CTR_EN
  logic [127:0] ctr_r;
  logic [127:0] din_r;
`endif

  assign key_fire_s     = bus.key_valid && key_ready_r;
  assign bus.in_ready   = in_open_r && !bus.key_valid;
  assign in_fire_s      = bus.in_valid && bus.in_ready;
  assign out_fire_s     = out_valid_r && bus.out_ready;
  assign bus.key_ready  = key_ready_r;
  assign bus.key_loaded = key_loaded_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.busy       = busy_r;

  // Next key-schedule block, next cipher state and block source (counter or plaintext)
  always_comb begin
    kexp_next_s  = key_step(rk_r[cnt_r - 4'd1], rk_r[cnt_r - NKB4], cnt_r);
    round_next_s = enc_round(st_r, rk_r[cnt_r], cnt_r == NR4);
`ifdef AES_STREAM_CTR_EN
    blk_src_s    = ctr_r;
    out_next_s   = round_next_s ^ din_r;
`else
    blk_src_s    = bus.in_data;
    out_next_s   = round_next_s;
`endif
  end

  // Control FSM with key schedule, round iteration and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      st_r         <= 128'h0;
      out_data_r   <= 128'h0;
      key_loaded_r <= 1'b0;
      key_ready_r  <= 1'b1;
      in_open_r    <= 1'b0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      for (int k = 0; k <= NR; k++) rk_r[k] <= 128'h0;
`ifdef AES_STREAM_CTR_EN
      ctr_r        <= 128'h0;
      din_r        <= 128'h0;
`endif
    end else if (key_fire_s) begin
      // key_ready is only high in IDLE/READY, so this restarts the schedule from either
      rk_r[0]      <= bus.key[KEY_BITS-1 -: 128];
      if (NK == 8) rk_r[1] <= bus.key[127:0];
      cnt_r        <= NKB4;
      state_r      <= KEY_EXP;
      key_loaded_r <= 1'b0;
      key_ready_r  <= 1'b0;
      in_open_r    <= 1'b0;
      busy_r       <= 1'b1;
`ifdef AES_STREAM_CTR_EN
      ctr_r        <= bus.ctr_init;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        KEY_EXP: begin
          rk_r[cnt_r] <= kexp_next_s;
          cnt_r       <= cnt_r + 4'd1;
          if (cnt_r == NR4) begin
            state_r      <= READY;
            key_loaded_r <= 1'b1;
            key_ready_r  <= 1'b1;
            in_open_r    <= 1'b1;
            busy_r       <= 1'b0;
          end
        end
        READY: begin
          if (in_fire_s) begin
            st_r        <= blk_src_s ^ rk_r[0];
            cnt_r       <= 4'd1;
            state_r     <= ROUND;
            key_ready_r <= 1'b0;
            in_open_r   <= 1'b0;
            busy_r      <= 1'b1;
`ifdef AES_STREAM_CTR_EN
            din_r       <= bus.in_data;
`endif
          end
        end
        ROUND: begin
          st_r  <= round_next_s;
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == NR4) begin
            out_data_r  <= out_next_s;
            out_valid_r <= 1'b1;
            state_r     <= OUT;
          end
        end
        OUT: begin
          if (out_fire_s) begin
            out_valid_r <= 1'b0;
            state_r     <= READY;
            key_ready_r <= 1'b1;
            in_open_r   <= 1'b1;
            busy_r      <= 1'b0;
`ifdef AES_STREAM_CTR_EN
            ctr_r       <= ctr_r + 128'd1;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_stream_core.sv
// Directed-vector bench for aes_stream_core: AES-128 and AES-256 instances, FIPS-197 vectors.
module tb_aes_stream_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  localparam logic [127:0] K_C1    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_FIPS = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_FIPS = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K_C3    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_stream_core_if #(.KEY_BITS(128)) bus ();
  aes_stream_core_if #(.KEY_BITS(256)) bus256 ();

  aes_stream_core #(.KEY_BITS(128)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  aes_stream_core #(.KEY_BITS(256)) dut256 (.clk(clk), .rst(rst), .bus(bus256.slave));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k, output int lat);
    bus.key = k;
    bus.key_valid = 1'b1;
    step();
    bus.key_valid = 1'b0;
    lat = 0;
    while (!bus.key_loaded && lat < 40) begin step(); lat++; end
  endtask

  task automatic run_block(input logic [127:0] d, output int lat, output logic [127:0] res);
    int w;
    bus.in_data = d;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 40) begin step(); w++; end
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin step(); lat++; end
    res = bus.out_data;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.key_valid = 1'b0; bus.key = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus256.key_valid = 1'b0; bus256.key = '0; bus256.in_valid = 1'b0; bus256.in_data = '0;
    bus256.out_ready = 1'b0;
`ifdef AES_STREAM_CTR_EN
    bus.ctr_init = '0;
    bus256.ctr_init = '0;
`endif
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++; if (bus.key_loaded !== 1'b0) begin errors++; $display("FAIL reset_key_loaded got=%0b exp=0", bus.key_loaded); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got=%0b exp=1", bus.key_ready); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
  endtask

  task automatic test_aes128();
    int lat;
    logic [127:0] res;
    bus.key = K_C1;
    bus.key_valid = 1'b1;
    step();
    bus.key_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.key_ready !== 1'b0 || bus.key_loaded !== 1'b0) begin
      errors++; $display("FAIL kexp_flags got busy=%0b key_ready=%0b key_loaded=%0b exp 1 0 0",
                         bus.busy, bus.key_ready, bus.key_loaded);
    end
    lat = 0;
    while (!bus.key_loaded && lat < 40) begin step(); lat++; end
    checks++; if (lat != 10) begin errors++; $display("FAIL key128_latency got=%0d exp=10", lat); end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL ready_flags got in_ready=%0b busy=%0b exp 1 0", bus.in_ready, bus.busy);
    end
    run_block(PT_C1, lat, res);
    checks++; if (lat != 10) begin errors++; $display("FAIL out128_latency got=%0d exp=10", lat); end
    checks++; if (res !== CT_C1) begin errors++; $display("FAIL aes128_c1 got=%h exp=%h", res, CT_C1); end
  endtask

  task automatic test_aes256();
    int lat;
    bus256.key = K_C3;
    bus256.key_valid = 1'b1;
    step();
    bus256.key_valid = 1'b0;
    lat = 0;
    while (!bus256.key_loaded && lat < 40) begin step(); lat++; end
    checks++; if (lat != 13) begin errors++; $display("FAIL key256_latency got=%0d exp=13", lat); end
    bus256.in_data = PT_C1;
    bus256.in_valid = 1'b1;
    step();
    bus256.in_valid = 1'b0;
    lat = 0;
    while (!bus256.out_valid && lat < 40) begin step(); lat++; end
    checks++; if (lat != 14) begin errors++; $display("FAIL out256_latency got=%0d exp=14", lat); end
    checks++; if (bus256.out_data !== CT_C3) begin errors++; $display("FAIL aes256_c3 got=%h exp=%h", bus256.out_data, CT_C3); end
    bus256.out_ready = 1'b1;
    step();
    bus256.out_ready = 1'b0;
    checks++;
    if (bus256.out_valid !== 1'b0 || bus256.in_ready !== 1'b1) begin
      errors++; $display("FAIL out256_release got out_valid=%0b in_ready=%0b exp 0 1", bus256.out_valid, bus256.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [127:0] res;
    load_key(K_FIPS, lat);
    bus.in_data = PT_FIPS;
    bus.in_valid = 1'b1;
    step();
    lat = 0;
    while (!bus.out_valid && lat < 40) begin step(); lat++; end
    checks++; if (lat != 10) begin errors++; $display("FAIL b2b_latency got=%0d exp=10", lat); end
    checks++; if (bus.out_data !== CT_FIPS) begin errors++; $display("FAIL b2b_fips got=%h exp=%h", bus.out_data, CT_FIPS); end
    // next block is already offered while the result stalls
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== CT_FIPS || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold cyc=%0d got out_valid=%0b out_data=%h in_ready=%0b exp 1 %h 0",
                           i, bus.out_valid, bus.out_data, bus.in_ready, CT_FIPS);
      end
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%0b exp=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin step(); lat++; end
    checks++; if (lat != 10 || bus.out_data !== CT_FIPS) begin
      errors++; $display("FAIL b2b_second got lat=%0d data=%h exp 10 %h", lat, bus.out_data, CT_FIPS);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    load_key(K_C1, lat);
    run_block(PT_C1, lat, res);
    checks++; if (res !== CT_C1) begin errors++; $display("FAIL b2b_reload_c1 got=%h exp=%h", res, CT_C1); end
  endtask

  task automatic test_key_priority();
    int lat;
    logic [127:0] res;
    bus.key = K_FIPS;
    bus.key_valid = 1'b1;
    bus.in_data = PT_FIPS;
    bus.in_valid = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL prio_in_ready got=%0b exp=0", bus.in_ready); end
    step();
    bus.key_valid = 1'b0;
    checks++;
    if (bus.key_loaded !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL prio_key_taken got key_loaded=%0b busy=%0b exp 0 1", bus.key_loaded, bus.busy);
    end
    lat = 0;
    while (!bus.key_loaded && lat < 40) begin step(); lat++; end
    checks++; if (lat != 10) begin errors++; $display("FAIL prio_key_latency got=%0d exp=10", lat); end
    run_block(PT_FIPS, lat, res);
    checks++; if (lat != 10) begin errors++; $display("FAIL prio_out_latency got=%0d exp=10", lat); end
    checks++; if (res !== CT_FIPS) begin errors++; $display("FAIL prio_new_key got=%h exp=%h", res, CT_FIPS); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int bad;
    load_key(K_C1, lat);
    bus.in_data = PT_C1;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.key_loaded !== 1'b0 || bus.key_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got out_valid=%0b key_loaded=%0b key_ready=%0b busy=%0b exp 0 0 1 0",
                         bus.out_valid, bus.key_loaded, bus.key_ready, bus.busy);
    end
    bus.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_no_accept got=%0d bad cycles exp=0", bad); end
  endtask

`ifdef AES_STREAM_CTR_EN
  task automatic test_ctr();
    int lat;
    logic [127:0] res;
    bus.ctr_init = PT_C1;
    load_key(K_C1, lat);
    run_block(128'h0, lat, res);
    checks++; if (res !== CT_C1) begin errors++; $display("FAIL ctr_first got=%h exp=%h", res, CT_C1); end
    bus.ctr_init = PT_C1 - 128'd1;
    load_key(K_C1, lat);
    run_block(128'h0, lat, res);
    run_block(128'hffffffffffffffffffffffffffffffff, lat, res);
    checks++; if (res !== ~CT_C1) begin errors++; $display("FAIL ctr_increment got=%h exp=%h", res, ~CT_C1); end
    bus.ctr_init = 128'hffffffffffffffffffffffffffffffff;
    load_key(128'h0, lat);
    run_block(128'h0, lat, res);
    run_block(128'h0, lat, res);
    checks++;
    if (res !== 128'h66e94bd4ef8a2c3b884cfa59ca342b2e) begin
      errors++; $display("FAIL ctr_wrap got=%h exp=66e94bd4ef8a2c3b884cfa59ca342b2e", res);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef AES_STREAM_CTR_EN
    test_ctr();
`else
    test_aes128();
    test_aes256();
    test_back_to_back();
    test_key_priority();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
